// File: rtl/switch_detect_multi.sv
// switch_detect_multi: independent per-channel switch edge detectors with
// a 2-FF synchronizer, post-detect lockout and a long-press report.
module switch_detect_multi #(
    parameter int CHANNELS       = 4,
    parameter int LOCKOUT_CYCLES = 100000,
    parameter int LONG_CYCLES    = 5000000,
    parameter int CNT_W          = 23,
    parameter int EDGE_MODE      = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] switch_in,
    output logic [CHANNELS-1:0] detected,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] busy
);
    typedef enum logic [1:0] {IDLE, LOCK, HELD} state_t;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state, nxt;
        logic             s1, s2, prev, lvl, edg, det, lp;
        logic [CNT_W-1:0] lock_cnt, long_cnt;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                prev     <= 1'b0;
                state    <= IDLE;
                det      <= 1'b0;
                lp       <= 1'b0;
                lock_cnt <= '0;
                long_cnt <= '0;
            end else begin
                s1       <= switch_in[c];
                s2       <= s1;
                prev     <= s2;
                state    <= nxt;
                det      <= (state == IDLE) && edg;
                // long_cnt reaches LONG_MAX on this same edge, so the pulse lines up with saturation
                lp       <= (state == HELD) && lvl && (long_cnt == LONG_PRE);
                lock_cnt <= (state == IDLE) ? (edg ? LOCK_LOAD : lock_cnt)
                          : (lock_cnt != '0) ? lock_cnt - ONE : '0;
                long_cnt <= (state == IDLE) ? '0
                          : (long_cnt != LONG_MAX) ? long_cnt + ONE : long_cnt;
            end
        end
        always_comb begin
            lvl = (EDGE_MODE == 1) ? ~s2 : s2;
            edg = (EDGE_MODE == 0) ? (s2 & ~prev)
                : (EDGE_MODE == 1) ? (~s2 & prev)
                : (s2 ^ prev);
            nxt = (state == IDLE) ? (edg ? LOCK : IDLE)
                : (state == LOCK) ? ((lock_cnt != '0) ? LOCK
                                    : ((EDGE_MODE != 2) && lvl) ? HELD : IDLE)
                : (state == HELD) ? (lvl ? HELD : IDLE)
                : IDLE;
        end
        assign busy[c]       = (state != IDLE);
        assign detected[c]   = det;
        assign long_press[c] = lp;
    end
endmodule

// File: tb/tb_switch_detect_multi.sv
// tb_switch_detect_multi: three instances (rising, falling, both-edge modes) driven
// by shared stimulus and compared every cycle against a timeline-based reference model.
module tb_switch_detect_multi;
    localparam int LOCKOUT = 8;
    localparam int LONG    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw  = 2'b00;
    logic [1:0] det[3], lp[3], busy[3];
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    switch_detect_multi #(.CHANNELS(2), .LOCKOUT_CYCLES(LOCKOUT), .LONG_CYCLES(LONG), .CNT_W(5), .EDGE_MODE(0))
        dut0 (.CLK(clk), .RST(rst), .switch_in(sw), .detected(det[0]), .long_press(lp[0]), .busy(busy[0]));
    switch_detect_multi #(.CHANNELS(2), .LOCKOUT_CYCLES(LOCKOUT), .LONG_CYCLES(LONG), .CNT_W(5), .EDGE_MODE(1))
        dut1 (.CLK(clk), .RST(rst), .switch_in(sw), .detected(det[1]), .long_press(lp[1]), .busy(busy[1]));
    switch_detect_multi #(.CHANNELS(2), .LOCKOUT_CYCLES(LOCKOUT), .LONG_CYCLES(LONG), .CNT_W(5), .EDGE_MODE(2))
        dut2 (.CLK(clk), .RST(rst), .switch_in(sw), .detected(det[2]), .long_press(lp[2]), .busy(busy[2]));

    // reference model: input history in raw samples plus remaining-lockout and press-age bookkeeping
    int         lock_left[3][2];
    int         age[3][2];
    bit         held[3][2];
    bit         fired[3][2];
    bit         h1[2], h2[2], h3[2];
    logic [1:0] m_det[3], m_lp[3], m_busy[3];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < 2; c++) begin
                lock_left[m][c] = 0;
                age[m][c]       = 0;
                held[m][c]      = 1'b0;
                fired[m][c]     = 1'b0;
            end
            m_det[m]  = 2'b00;
            m_lp[m]   = 2'b00;
            m_busy[m] = 2'b00;
        end
        for (int c = 0; c < 2; c++) begin
            h1[c] = 1'b0;
            h2[c] = 1'b0;
            h3[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [1:0] x);
        for (int c = 0; c < 2; c++) begin
            bit a, b;
            a = h2[c];
            b = h3[c];
            for (int m = 0; m < 3; m++) begin
                bit lvl, qual;
                lvl  = (m == 1) ? !a : a;
                qual = (m == 0) ? (a && !b) : (m == 1) ? (!a && b) : (a != b);
                m_det[m][c] = 1'b0;
                m_lp[m][c]  = 1'b0;
                if (lock_left[m][c] > 0) begin
                    lock_left[m][c]--;
                    age[m][c]++;
                    if (lock_left[m][c] == 0) held[m][c] = (m != 2) && lvl;
                end else if (held[m][c]) begin
                    if (!lvl) held[m][c] = 1'b0;
                    else begin
                        if (age[m][c] < LONG - 1) age[m][c]++;
                        if (age[m][c] == LONG - 1 && !fired[m][c]) begin
                            m_lp[m][c]  = 1'b1;
                            fired[m][c] = 1'b1;
                        end
                    end
                end else if (qual) begin
                    m_det[m][c]     = 1'b1;
                    lock_left[m][c] = LOCKOUT;
                    age[m][c]       = 0;
                    fired[m][c]     = 1'b0;
                end
                m_busy[m][c] = (lock_left[m][c] > 0) || held[m][c];
            end
            h3[c] = h2[c];
            h2[c] = h1[c];
            h1[c] = x[c];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int m = 0; m < 3; m++)
            check($sformatf("model_m%0d", m), {26'd0, det[m], lp[m], busy[m]},
                  {26'd0, m_det[m], m_lp[m], m_busy[m]});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(sw);
        #1;
        compare_model();
    endtask

    // called at edge+1: asserts reset mid-cycle, checks async clear, holds over one edge
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", {det[0], lp[0], busy[0], det[1], lp[1], busy[1], det[2], lp[2], busy[2]}, 0);
        tick();
        #3;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] sw;
        logic [1:0] det;
        logic [1:0] busy;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int det_cnt, lp_cnt, det_edge, lp_edge, det2_cnt, lp2_cnt;
        bit busy2_gap;
        logic [1:0] bounce[10];
        model_reset();
        for (int i = 0; i < 12; i++) tbl[i] = '{(i < 4) ? 2'b01 : 2'b00, 2'b00, 2'b00};
        tbl[2].det = 2'b01;
        for (int i = 2; i <= 9; i++) tbl[i].busy = 2'b01;
        bounce = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {det[0], lp[0], busy[0]}, 0);
        #3;
        rst = 1'b0;
        repeat (3) tick();

        // single short press on ch0: pulse on edge 3, lockout over edges 3..10
        for (int i = 0; i < 12; i++) begin
            sw = tbl[i].sw;
            tick();
            check($sformatf("tbl_det_%0d", i), det[0], tbl[i].det);
            check($sformatf("tbl_busy_%0d", i), busy[0], tbl[i].busy);
            check($sformatf("tbl_lp_%0d", i), lp[0], 2'b00);
        end

        // bounces inside lockout give one pulse; a later clean press gives another
        pulse_reset();
        repeat (3) tick();
        det_cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            sw = (e <= 10) ? bounce[e-1] : 2'b00;
            tick();
            det_cnt += det[0][0];
        end
        check("bounce_one_pulse", det_cnt, 1);
        det_cnt = 0;
        for (int e = 21; e <= 35; e++) begin
            sw = (e <= 25) ? 2'b01 : 2'b00;
            tick();
            det_cnt += det[0][0];
        end
        check("second_press", det_cnt, 1);

        // long hold: detect edge 3, long_press edge 3+LONG-1, once only
        pulse_reset();
        repeat (3) tick();
        sw = 2'b01;
        lp_cnt = 0; lp_edge = 0; det_edge = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (det[0][0]) det_edge = e;
            if (lp[0][0]) begin lp_cnt++; lp_edge = e; end
        end
        check("long_det_edge", det_edge, 3);
        check("long_lp_edge", lp_edge, 3 + LONG - 1);
        check("long_lp_once", lp_cnt, 1);
        sw = 2'b00;
        tick();
        tick();
        check("held_busy_before_release", busy[0][0], 1'b1);
        tick();
        check("busy_drop_after_release", busy[0][0], 1'b0);

        // both-edge mode on ch1: two pulses, no long_press, idle gap between
        pulse_reset();
        repeat (3) tick();
        det2_cnt = 0; lp2_cnt = 0; busy2_gap = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            sw = (e <= 12) ? 2'b10 : 2'b00;
            tick();
            det2_cnt += det[2][1];
            lp2_cnt  += lp[2][1];
            if (e == 13 && !busy[2][1]) busy2_gap = 1'b1;
        end
        check("both_two_pulses", det2_cnt, 2);
        check("both_no_long", lp2_cnt, 0);
        check("both_busy_gap", busy2_gap, 1'b1);

        // reset mid-lockout, then both switches already pressed -> one simultaneous detection
        pulse_reset();
        repeat (3) tick();
        sw = 2'b01;
        repeat (5) tick();
        check("pre_reset_busy", busy[0], 2'b01);
        sw = 2'b11;
        pulse_reset();
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("post_rst_det_%0d", e), det[0], (e == 3) ? 2'b11 : 2'b00);
        end

        // randomized segments with varying toggle rates, one async reset in the middle
        for (int seg = 0; seg < 80; seg++) begin
            int rate;
            rate = $urandom_range(1, 30);
            if (seg == 40) pulse_reset();
            repeat (25) begin
                for (int c = 0; c < 2; c++)
                    if ($urandom_range(0, rate) == 0) sw[c] = ~sw[c];
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
